// File: rtl/trace_arbiter_pkg.sv
// Shared types and default parameters for the trace arbiter slice.
package trace_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int TS_W_DEF    = 32;
  localparam int DEPTH_DEF   = 4;
  localparam int SRC_W_DEF   = $clog2(NUM_REQ_DEF);

  // Field order matches the packed record stored in trace_fifo (ts in the MSBs).
  typedef struct packed {
    logic [TS_W_DEF-1:0]   ts;
    logic [SRC_W_DEF-1:0]  src;
    logic [DATA_W_DEF-1:0] data;
  } trace_rec_t;

  function automatic int rec_width(input int ts_w, input int num_req, input int data_w);
    return ts_w + $clog2(num_req) + data_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding packed trace records; head is read straight from storage.
module trace_fifo
  import trace_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = rec_width(TS_W_DEF, NUM_REQ_DEF, DATA_W_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push && (count_r != (AW+1)'(DEPTH));
  assign do_pop_s  = pop && (count_r != {(AW+1){1'b0}});

  // Storage array, no reset needed: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push_s && !reset) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_r <= do_push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r <= do_pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/trace_arbiter.sv
// Round-robin trace arbiter: grants one requester per cycle, timestamps the
// record with the free-running tsc and queues it for the sink.
module trace_arbiter
  import trace_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TS_W    = TS_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TS_W-1:0]             out_ts,
  output logic [$clog2(NUM_REQ)-1:0]  out_src,
  output logic [DATA_W-1:0]           out_data,
  output logic [TS_W-1:0]             tsc
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int REC_W = rec_width(TS_W, NUM_REQ, DATA_W);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic [TS_W-1:0]  tsc_r;
  logic [SRC_W-1:0] last_grant_r;
  logic             found_s;
  logic [SRC_W-1:0] grant_idx_s;
  logic             full_s;
  logic [CW-1:0]    fifo_count_s;
  logic [REC_W-1:0] push_data_s;
  logic [REC_W-1:0] head_s;
  logic             pop_s;

  assign full_s = (fifo_count_s == CW'(DEPTH));

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = {SRC_W{1'b0}};
    if (reset || !en || full_s) begin
      found_s = 1'b0;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found_s && req_valid[(int'(last_grant_r) + k) % NUM_REQ]) begin
          found_s     = 1'b1;
          grant_idx_s = SRC_W'((int'(last_grant_r) + k) % NUM_REQ);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  assign req_ready   = found_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s) : {NUM_REQ{1'b0}};
  assign push_data_s = {tsc_r, grant_idx_s, req_data[int'(grant_idx_s)*DATA_W +: DATA_W]};

  // Free-running timestamp and round-robin pointer; reset favours requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      tsc_r        <= {TS_W{1'b0}};
      last_grant_r <= SRC_W'(NUM_REQ - 1);
    end else begin
      tsc_r        <= tsc_r + TS_W'(1);
      last_grant_r <= found_s ? grant_idx_s : last_grant_r;
    end
  end

  assign out_valid = (fifo_count_s != {CW{1'b0}});
  assign pop_s     = out_valid && out_ready;

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (found_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s)
  );

  assign out_ts   = head_s[REC_W-1 -: TS_W];
  assign out_src  = head_s[DATA_W +: SRC_W];
  assign out_data = head_s[DATA_W-1:0];
  assign tsc      = tsc_r;

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: a queue-based model checked every cycle,
// plus literal expectations for the key scenarios. A TS_W=8 copy shares stimulus.
module tb_trace_arbiter;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic        out_ready;

  logic [3:0]  req_ready,  req_ready8;
  logic        out_valid,  out_valid8;
  logic [31:0] out_ts,     tsc;
  logic [7:0]  out_ts8,    tsc8;
  logic [1:0]  out_src,    out_src8;
  logic [15:0] out_data,   out_data8;

  int checks = 0;
  int errors = 0;

  trace_arbiter dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_ts(out_ts), .out_src(out_src), .out_data(out_data), .tsc(tsc)
  );

  trace_arbiter #(.TS_W(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready8), .out_valid(out_valid8), .out_ready(out_ready),
    .out_ts(out_ts8), .out_src(out_src8), .out_data(out_data8), .tsc(tsc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] ts;
    int          src;
    logic [15:0] data;
  } rec_t;

  rec_t        mq[$];
  logic [31:0] m_tsc  = 32'd0;
  int          m_last = 3;
  bit          m_init = 1'b0;

  // Model: compare at the falling edge, then advance by what the rising edge will do.
  always @(negedge clk) begin
    logic [3:0] exp_r;
    int         g;
    rec_t       r;
    exp_r = 4'b0;
    g     = -1;
    if (!reset && en && mq.size() < 4) begin
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && req_valid[(m_last + k) % 4]) g = (m_last + k) % 4;
      end
      if (g >= 0) exp_r[g] = 1'b1;
    end
    if (m_init) begin
      check("tsc", tsc, m_tsc);
      check("tsc8", tsc8, {56'd0, m_tsc[7:0]});
      check("req_ready", req_ready, exp_r);
      check("req_ready8", req_ready8, exp_r);
      check("out_valid", out_valid, mq.size() != 0);
      check("out_valid8", out_valid8, mq.size() != 0);
      if (mq.size() != 0) begin
        check("out_ts", out_ts, mq[0].ts);
        check("out_ts8", out_ts8, {56'd0, mq[0].ts[7:0]});
        check("out_src", out_src, mq[0].src);
        check("out_data", out_data, mq[0].data);
        check("out_data8", out_data8, mq[0].data);
      end
    end
    if (reset) begin
      mq.delete();
      m_tsc  = 32'd0;
      m_last = 3;
      m_init = 1'b1;
    end else if (m_init) begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (g >= 0) begin
        r.ts   = m_tsc;
        r.src  = g;
        r.data = req_data[g*16 +: 16];
        mq.push_back(r);
        m_last = g;
      end
      m_tsc = m_tsc + 32'd1;
    end
  end

  initial begin
    int          pushes;
    logic [31:0] tsv [4];

    reset = 1'b1; en = 1'b0; req_valid = 4'b0; req_data = 64'd0; out_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    // Single record from requester 0 in cycle 5 after reset.
    en = 1'b1;
    repeat (5) step();
    req_valid = 4'b0001; req_data[15:0] = 16'h00AA; out_ready = 1'b1;
    @(negedge clk);
    check("r035_ready", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    check("r035_valid", out_valid, 1'b1);
    check("r035_src", out_src, 2'd0);
    check("r035_data", out_data, 16'h00AA);
    check("r035_ts", out_ts, 32'd5);
    step();

    // All requesters valid: strict rotation starting at 0.
    reset = 1'b1; step(); reset = 1'b0;
    req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("r036_grant", req_ready, 4'b0001 << (k % 4));
      if (k > 0) check("r036_src", out_src, (k - 1) % 4);
      step();
    end
    req_valid = 4'b0000;
    step();

    // Fill with the sink stalled, then drain.
    out_ready = 1'b0; req_valid = 4'b0100; pushes = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_ready != 4'b0) pushes++;
      step();
    end
    check("r037_pushes", pushes, 4);
    req_valid = 4'b0000; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("r037_drain_valid", out_valid, 1'b1);
      tsv[k] = out_ts;
      step();
    end
    for (int k = 0; k < 3; k++) check("r037_ts_consec", tsv[k+1], tsv[k] + 32'd1);
    req_valid = 4'b0100;
    @(negedge clk);
    check("r037_resume", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    step();

    // Full FIFO with a pop in the same cycle still blocks the grant.
    out_ready = 1'b0; req_valid = 4'b0001;
    repeat (4) step();
    out_ready = 1'b1;
    @(negedge clk);
    check("r038_blocked", req_ready, 4'b0000);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("r038_grant", req_ready, 4'b0001);
    step();
    @(negedge clk);
    check("r038_full", req_ready, 4'b0000);
    check("r038_count", dut.u_fifo.count, 3'd4);
    req_valid = 4'b0000; out_ready = 1'b1;
    repeat (5) step();

    // Disabling arbitration must not stop the drain.
    out_ready = 1'b0; req_valid = 4'b1010;
    repeat (2) step();
    en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("r028_no_grant", req_ready, 4'b0000);
    repeat (3) step();
    @(negedge clk);
    check("r028_drained", out_valid, 1'b0);
    en = 1'b1; req_valid = 4'b0000;

    // Mixed directed patterns, checked by the model only.
    for (int i = 0; i < 24; i++) begin
      req_valid = 4'(i * 7 + 3);
      out_ready = ((i % 2) != 0) ^ ((i % 8) >= 4);
      en        = (i % 5) != 4;
      req_data  = {16'(i * 4 + 3), 16'(i * 4 + 2), 16'(i * 4 + 1), 16'(i * 4)};
      step();
    end

    // Timestamp wrap on the 8-bit build.
    reset = 1'b1; req_valid = 4'b0000; en = 1'b1; out_ready = 1'b1;
    step();
    reset = 1'b0;
    repeat (255) step();
    req_valid = 4'b0011; req_data = {16'h0, 16'h0, 16'h0F0F, 16'hF0F0};
    @(negedge clk);
    check("r039_tsc8", tsc8, 8'hFF);
    step();
    @(negedge clk);
    check("r039_ts_ff", out_ts8, 8'hFF);
    check("r039_src0", out_src8, 2'd0);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    check("r039_ts_00", out_ts8, 8'h00);
    check("r039_src1", out_src8, 2'd1);
    repeat (2) step();

    // Reset with records queued.
    out_ready = 1'b0; req_valid = 4'b0010;
    repeat (3) step();
    reset = 1'b1; req_valid = 4'b1001;
    @(negedge clk);
    check("r040_ready_in_reset", req_ready, 4'b0000);
    check("r040_queued", out_valid, 1'b1);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("r040_flushed", out_valid, 1'b0);
    check("r040_tsc", tsc, 32'd0);
    check("r040_first", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000; out_ready = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
